// File: rtl/vga_pkg.sv
// Shared 640x480@60 raster constants and RRRGGGBB colour helpers.
// Also imported by vga_handler so both sides agree on timing and pixel layout.
package vga_pkg;

    localparam int H_VISIBLE = 640;
    localparam int H_FP      = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BP      = 48;
    localparam int H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;

    localparam int V_VISIBLE = 480;
    localparam int V_FP      = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BP      = 33;
    localparam int V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam logic SYNC_POL   = 1'b0;
    localparam int   PIPE_DELAY = 2;

    // rgb332 field positions inside the 8-bit pixel
    localparam int R_MSB = 7;
    localparam int R_LSB = 5;
    localparam int G_MSB = 4;
    localparam int G_LSB = 2;
    localparam int B_MSB = 1;
    localparam int B_LSB = 0;

    function automatic logic [7:0] expand3to8(input logic [2:0] c);
        return {c, c, c[2:1]};
    endfunction

    function automatic logic [7:0] expand2to8(input logic [1:0] c);
        return {c, c, c, c};
    endfunction

endpackage

// File: rtl/vga_timing_gen_sync_delay_line.sv
// Shift register that delays raster decodes to line up with the returning pixel.
// DEPTH=0 degenerates to a wire.
module sync_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             vga_clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] rst_val,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_wire
            assign dout = din;
        end else begin : g_pipe
            logic [WIDTH-1:0] stage [DEPTH];

            always_ff @(posedge vga_clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < DEPTH; i++) stage[i] <= rst_val;
                end else begin
                    stage[0] <= din;
                    for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
                end
            end

            assign dout = stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// Free-running raster counters, sync/blank decode aligned to renderer latency,
// and RRRGGGBB -> 8:8:8 expansion into a single output register for the DAC pins.
module vga_timing_gen #(
    parameter int   H_VISIBLE  = vga_pkg::H_VISIBLE,
    parameter int   H_FP       = vga_pkg::H_FP,
    parameter int   H_SYNC     = vga_pkg::H_SYNC,
    parameter int   H_BP       = vga_pkg::H_BP,
    parameter int   V_VISIBLE  = vga_pkg::V_VISIBLE,
    parameter int   V_FP       = vga_pkg::V_FP,
    parameter int   V_SYNC     = vga_pkg::V_SYNC,
    parameter int   V_BP       = vga_pkg::V_BP,
    parameter logic SYNC_POL   = vga_pkg::SYNC_POL,
    parameter int   PIPE_DELAY = vga_pkg::PIPE_DELAY
) (
    input  logic       vga_clk,
    input  logic       rst_n,
    input  logic [7:0] pixel_in,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       frame_tick,
    output logic       vga_hs,
    output logic       vga_vs,
    output logic       vga_blank_n,
    output logic       vga_sync_n,
    output logic [7:0] vga_r,
    output logic [7:0] vga_g,
    output logic [7:0] vga_b
);

    localparam int H_TOT = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST   = 10'(H_TOT - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOT - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FP + V_SYNC);

    logic [9:0] h_cnt;
    logic [9:0] v_cnt;
    logic       vis;
    logic       hs_raw;
    logic       vs_raw;
    logic [2:0] dly;

    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
        end else begin
            h_cnt <= h_cnt + 10'd1;
        end
    end

    // Pulse lands the clock after the counters enter the first blank line.
    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) frame_tick <= 1'b0;
        else        frame_tick <= (h_cnt == '0) && (v_cnt == V_VIS);
    end

    assign x = h_cnt;
    assign y = v_cnt;

    assign vis    = (h_cnt < H_VIS) && (v_cnt < V_VIS);
    assign hs_raw = (h_cnt >= HS_START) && (h_cnt < HS_END);
    assign vs_raw = (v_cnt >= VS_START) && (v_cnt < VS_END);

    sync_delay_line #(
        .WIDTH(3),
        .DEPTH(PIPE_DELAY)
    ) u_sync_dly (
        .vga_clk(vga_clk),
        .rst_n  (rst_n),
        .rst_val(3'b000),
        .din    ({vis, hs_raw, vs_raw}),
        .dout   (dly)
    );

    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            vga_hs      <= ~SYNC_POL;
            vga_vs      <= ~SYNC_POL;
            vga_blank_n <= 1'b0;
            vga_r       <= '0;
            vga_g       <= '0;
            vga_b       <= '0;
        end else begin
            vga_hs      <= dly[1] ^ ~SYNC_POL;
            vga_vs      <= dly[0] ^ ~SYNC_POL;
            vga_blank_n <= dly[2];
            if (dly[2]) begin
                vga_r <= vga_pkg::expand3to8(pixel_in[vga_pkg::R_MSB:vga_pkg::R_LSB]);
                vga_g <= vga_pkg::expand3to8(pixel_in[vga_pkg::G_MSB:vga_pkg::G_LSB]);
                vga_b <= vga_pkg::expand2to8(pixel_in[vga_pkg::B_MSB:vga_pkg::B_LSB]);
            end else begin
                vga_r <= '0;
                vga_g <= '0;
                vga_b <= '0;
            end
        end
    end

    assign vga_sync_n = 1'b0;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen with a shortened vertical raster so a full
// frame fits in a short run; expected pins come from a bench-side scoreboard.
module tb_vga_timing_gen;
    import vga_pkg::*;

    localparam int TV_VIS   = 24;
    localparam int TV_FP    = 3;
    localparam int TV_SYNC  = 2;
    localparam int TV_BP    = 2;
    localparam int TV_TOTAL = TV_VIS + TV_FP + TV_SYNC + TV_BP;
    localparam int PD       = 2;
    localparam int FRAME    = H_TOTAL * TV_TOTAL;

    localparam int M_ALIGN = 0;
    localparam int M_EXP   = 1;
    localparam int M_RAND  = 2;
    localparam int M_FF    = 3;

    logic       vga_clk = 1'b0;
    logic       rst_n;
    logic [7:0] pixel_in;
    logic [9:0] x, y;
    logic       frame_tick, vga_hs, vga_vs, vga_blank_n, vga_sync_n;
    logic [7:0] vga_r, vga_g, vga_b;

    vga_timing_gen #(
        .H_VISIBLE(H_VISIBLE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_VISIBLE(TV_VIS), .V_FP(TV_FP), .V_SYNC(TV_SYNC), .V_BP(TV_BP),
        .SYNC_POL(SYNC_POL), .PIPE_DELAY(PD)
    ) dut (
        .vga_clk(vga_clk), .rst_n(rst_n), .pixel_in(pixel_in),
        .x(x), .y(y), .frame_tick(frame_tick),
        .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank_n(vga_blank_n),
        .vga_sync_n(vga_sync_n), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b)
    );

    always #20 vga_clk = ~vga_clk;

    typedef struct {
        logic       hs;
        logic       vs;
        logic       blank_n;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        int         kind;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] pq[$];

    int   errors = 0;
    int   checks = 0;
    int   mh, mv, mode, cyc, ticks, last_tick, hs_low, vs_low, budget;
    logic exp_tick, prev_vs;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t inactive_entry();
        exp_t e;
        e.hs = ~SYNC_POL; e.vs = ~SYNC_POL; e.blank_n = 1'b0;
        e.r = 8'h00; e.g = 8'h00; e.b = 8'h00; e.kind = 0;
        return e;
    endfunction

    // Called once per clock, mid-cycle: compare, then push this cycle's pixel.
    task automatic cycle_check();
        exp_t       e, n;
        logic       vis, hsr, vsr;
        logic [7:0] p;

        chk("xy", {x, y}, {10'(mh), 10'(mv)});
        chk("frame_tick", frame_tick, exp_tick);

        e = sb.pop_front();
        chk("pins", {vga_hs, vga_vs, vga_blank_n, vga_sync_n, vga_r, vga_g, vga_b},
            {e.hs, e.vs, e.blank_n, 1'b0, e.r, e.g, e.b});
        if (e.kind == 1) chk("align_red", {vga_r, vga_blank_n}, {8'hFF, 1'b1});
        if (e.kind == 2) chk("expand", {vga_r, vga_g, vga_b}, 24'hB64955);
        if (vga_blank_n === 1'b0 && mode == M_FF) chk("blank_mask", {vga_r, vga_g, vga_b}, 24'h0);

        if (frame_tick === 1'b1) begin
            if (ticks > 0) begin
                chk("tick_interval", cyc - last_tick, FRAME);
                chk("hs_low_per_frame", hs_low, H_SYNC * TV_TOTAL);
                chk("vs_low_per_frame", vs_low, TV_SYNC * H_TOTAL);
            end
            ticks++;
            last_tick = cyc;
            hs_low = 0;
            vs_low = 0;
        end
        if (vga_hs === 1'b0) hs_low++;
        if (vga_vs === 1'b0) vs_low++;
        if (prev_vs === 1'b1 && vga_vs === 1'b0 && ticks > 0)
            chk("vs_start", cyc - last_tick, TV_FP * H_TOTAL + PD);
        prev_vs = vga_vs;

        vis = (mh < H_VISIBLE) && (mv < TV_VIS);
        hsr = (mh >= H_VISIBLE + H_FP) && (mh < H_VISIBLE + H_FP + H_SYNC);
        vsr = (mv >= TV_VIS + TV_FP) && (mv < TV_VIS + TV_FP + TV_SYNC);
        case (mode)
            M_ALIGN: p = (mh == 5 && mv == 7) ? 8'hE0 : 8'h00;
            M_EXP:   p = 8'b101_010_01;
            M_FF:    p = 8'hFF;
            default: p = 8'($urandom);
        endcase
        n.hs      = hsr ? SYNC_POL : ~SYNC_POL;
        n.vs      = vsr ? SYNC_POL : ~SYNC_POL;
        n.blank_n = vis;
        n.r       = vis ? {p[7:5], p[7:5], p[7:6]} : 8'h00;
        n.g       = vis ? {p[4:2], p[4:2], p[4:3]} : 8'h00;
        n.b       = vis ? {4{p[1:0]}} : 8'h00;
        n.kind    = (mode == M_ALIGN && mh == 5 && mv == 7) ? 1 :
                    (mode == M_EXP && vis) ? 2 : 0;
        sb.push_back(n);

        pq.push_back(p);
        if (pq.size() > PD) pixel_in = pq.pop_front();
        else                pixel_in = 8'($urandom);

        exp_tick = (mh == 0 && mv == TV_VIS);
        if (mh == H_TOTAL - 1) begin
            mh = 0;
            mv = (mv == TV_TOTAL - 1) ? 0 : mv + 1;
        end else begin
            mh = mh + 1;
        end
        cyc++;
    endtask

    task automatic advance();
        @(posedge vga_clk);
        @(negedge vga_clk);
        cycle_check();
    endtask

    task automatic release_reset();
        @(negedge vga_clk);
        rst_n = 1'b1;
        mh = 0; mv = 0; exp_tick = 1'b0; cyc = 0;
        ticks = 0; last_tick = 0; hs_low = 0; vs_low = 0; prev_vs = 1'b1;
        sb.delete();
        pq.delete();
        for (int i = 0; i <= PD; i++) sb.push_back(inactive_entry());
        cycle_check();
    endtask

    initial begin
        rst_n    = 1'b0;
        pixel_in = 8'h00;
        mode     = M_ALIGN;
        repeat (3) @(negedge vga_clk);
        chk("rst_xy", {x, y}, 20'h0);
        chk("rst_tick", frame_tick, 1'b0);
        chk("rst_pins", {vga_hs, vga_vs, vga_blank_n, vga_sync_n, vga_r, vga_g, vga_b},
            {1'b1, 1'b1, 1'b0, 1'b0, 24'h0});

        release_reset();
        repeat (800) advance();
        chk("line1_x", x, 10'd0);
        chk("line1_y", y, 10'd1);

        budget = 0;
        while (!(mh == 0 && mv == 8) && budget < FRAME) begin advance(); budget++; end
        mode = M_EXP;
        while (!(mh == 0 && mv == 10) && budget < FRAME) begin advance(); budget++; end
        mode = M_RAND;
        while (!(mh == 300 && mv == 14) && budget < FRAME) begin advance(); budget++; end
        chk("reach_300_14", budget < FRAME, 1'b1);

        @(posedge vga_clk);
        @(negedge vga_clk);
        chk("pre_reset_xy", {x, y}, {10'd300, 10'd14});
        rst_n = 1'b0;
        #1;
        chk("async_rst_xy", {x, y}, 20'h0);
        chk("async_rst_tick", frame_tick, 1'b0);
        chk("async_rst_pins", {vga_hs, vga_vs, vga_blank_n, vga_r, vga_g, vga_b},
            {1'b1, 1'b1, 1'b0, 24'h0});
        repeat (4) @(negedge vga_clk);

        mode = M_FF;
        release_reset();
        repeat (800) advance();
        chk("restart_x", x, 10'd0);
        chk("restart_y", y, 10'd1);

        budget = 0;
        while (ticks < 2 && budget < 3 * FRAME) begin advance(); budget++; end
        chk("two_frame_ticks", ticks, 2);
        repeat (10) advance();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
